// File: rtl/framebuffer_writer.sv
// Framebuffer writer: clips raster pixels, packs them to RGB565, buffers them in a
// small FIFO and issues one memory word write per pixel over a req/ack handshake.
module framebuffer_writer #(
  parameter int FB_WIDTH   = 320,
  parameter int FB_HEIGHT  = 240,
  parameter int FIFO_DEPTH = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_write_pixel,
  input  logic [15:0]                 i_x,
  input  logic [15:0]                 i_y,
  input  logic [7:0]                  i_r,
  input  logic [7:0]                  i_g,
  input  logic [7:0]                  i_b,
  output logic                        o_mem_req,
  output logic [19:0]                 o_mem_addr,
  output logic [15:0]                 o_mem_data,
  input  logic                        i_mem_ack,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
  output logic                        o_overflow,
  input  logic                        i_clear_overflow,
  output logic [15:0]                 o_clip_count,
  output logic [15:0]                 o_drop_count,
  output logic                        o_idle
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t             state_q, state_d;
  logic               cap_vld_q, cap_vld_d;
  logic [15:0]        cap_x_q, cap_x_d, cap_y_q, cap_y_d;
  logic [7:0]         cap_r_q, cap_r_d, cap_g_q, cap_g_d, cap_b_q, cap_b_d;
  logic               req_q, req_d;
  logic [19:0]        addr_q, addr_d;
  logic [15:0]        data_q, data_d;
  logic [AW:0]        wp_q, wp_d, rp_q, rp_d;
  logic               ovf_q, ovf_d;
  logic [15:0]        clip_q, clip_d, drop_q, drop_d;
  logic [19:0]        fa_q [FIFO_DEPTH];
  logic [19:0]        fa_d [FIFO_DEPTH];
  logic [15:0]        fd_q [FIFO_DEPTH];
  logic [15:0]        fd_d [FIFO_DEPTH];

  logic signed [31:0] x_s, y_s;
  logic               in_range, pop, push, drop, clip, empty, full;
  logic [AW:0]        level;
  logic [31:0]        addr_full;
  logic [15:0]        pix_data;

  always_comb begin
    cap_vld_d = i_write_pixel;
    cap_x_d   = i_x;
    cap_y_d   = i_y;
    cap_r_d   = i_r;
    cap_g_d   = i_g;
    cap_b_d   = i_b;

    x_s       = {{16{cap_x_q[15]}}, cap_x_q};
    y_s       = {{16{cap_y_q[15]}}, cap_y_q};
    in_range  = (x_s >= 0) && (x_s < FB_WIDTH) && (y_s >= 0) && (y_s < FB_HEIGHT);
    // Only consumed when in range, so the coordinates are known non-negative here.
    addr_full = 32'(BASE_ADDR) + {16'd0, cap_y_q} * 32'(FB_WIDTH) + {16'd0, cap_x_q};
    pix_data  = {cap_r_q[7:3], cap_g_q[7:2], cap_b_q[7:3]};

    level = wp_q - rp_q;
    empty = (level == '0);
    full  = (level == FULL_LVL);

    pop     = 1'b0;
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: pop = !empty;
      S_REQ: begin
        if (i_mem_ack) begin
          if (!empty) begin
            pop = 1'b1;
          end else begin
            state_d = S_IDLE;
            req_d   = 1'b0;
            addr_d  = '0;
            data_d  = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      state_d = S_REQ;
      req_d   = 1'b1;
      addr_d  = fa_q[rp_q[AW-1:0]];
      data_d  = fd_q[rp_q[AW-1:0]];
    end

    clip = cap_vld_q && !in_range;
    // A full FIFO still takes the pixel when the head leaves in the same cycle.
    push = cap_vld_q && in_range && (!full || pop);
    drop = cap_vld_q && in_range && full && !pop;

    fa_d = fa_q;
    fd_d = fd_q;
    if (push) begin
      fa_d[wp_q[AW-1:0]] = addr_full[19:0];
      fd_d[wp_q[AW-1:0]] = pix_data;
    end
    wp_d = push ? wp_q + 1'b1 : wp_q;
    rp_d = pop ? rp_q + 1'b1 : rp_q;

    clip_d = (clip && clip_q != 16'hFFFF) ? clip_q + 16'd1 : clip_q;
    drop_d = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    ovf_d  = drop ? 1'b1 : (i_clear_overflow ? 1'b0 : ovf_q);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cap_vld_q <= 1'b0;
      cap_x_q   <= '0;
      cap_y_q   <= '0;
      cap_r_q   <= '0;
      cap_g_q   <= '0;
      cap_b_q   <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      ovf_q     <= 1'b0;
      clip_q    <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      cap_vld_q <= cap_vld_d;
      cap_x_q   <= cap_x_d;
      cap_y_q   <= cap_y_d;
      cap_r_q   <= cap_r_d;
      cap_g_q   <= cap_g_d;
      cap_b_q   <= cap_b_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      ovf_q     <= ovf_d;
      clip_q    <= clip_d;
      drop_q    <= drop_d;
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge i_clk) begin
    fa_q <= fa_d;
    fd_q <= fd_d;
  end

  assign o_mem_req    = req_q;
  assign o_mem_addr   = addr_q;
  assign o_mem_data   = data_q;
  assign o_fifo_level = level;
  assign o_overflow   = ovf_q;
  assign o_clip_count = clip_q;
  assign o_drop_count = drop_q;
  assign o_idle       = !cap_vld_q && empty && (state_q == S_IDLE);

endmodule

// File: tb/tb_framebuffer_writer.sv
// Bench for framebuffer_writer: directed vector table, hand-written corner sequences
// and random traffic, all cross-checked every cycle against a queue-based model.
module tb_framebuffer_writer;
  localparam int W = 320;
  localparam int H = 240;
  localparam int DEPTH = 4;
  localparam int BASE = 0;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_write_pixel = 1'b0;
  logic [15:0] i_x = '0, i_y = '0;
  logic [7:0]  i_r = '0, i_g = '0, i_b = '0;
  logic        o_mem_req;
  logic [19:0] o_mem_addr;
  logic [15:0] o_mem_data;
  logic        i_mem_ack = 1'b0;
  logic [2:0]  o_fifo_level;
  logic        o_overflow;
  logic        i_clear_overflow = 1'b0;
  logic [15:0] o_clip_count, o_drop_count;
  logic        o_idle;

  framebuffer_writer #(.FB_WIDTH(W), .FB_HEIGHT(H), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_write_pixel(i_write_pixel),
    .i_x(i_x), .i_y(i_y), .i_r(i_r), .i_g(i_g), .i_b(i_b),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .i_mem_ack(i_mem_ack), .o_fifo_level(o_fifo_level), .o_overflow(o_overflow),
    .i_clear_overflow(i_clear_overflow), .o_clip_count(o_clip_count),
    .o_drop_count(o_drop_count), .o_idle(o_idle)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending writes plus the write currently offered.
  typedef struct packed {logic [19:0] a; logic [15:0] d;} wr_t;
  wr_t mq[$];
  wr_t m_out;
  bit  m_out_v, m_cap_v, m_ovf;
  int  m_cx, m_cy, m_clip, m_drop;
  logic [7:0] m_cr, m_cg, m_cb;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mq.delete();
      m_out = '0; m_out_v = 0; m_cap_v = 0; m_ovf = 0;
      m_clip = 0; m_drop = 0; m_cx = 0; m_cy = 0;
      m_cr = '0; m_cg = '0; m_cb = '0;
    end else begin
      bit pop, inr, nov;
      wr_t nw;
      int a;
      pop = 0;
      if (!m_out_v) pop = (mq.size() > 0);
      else if (i_mem_ack) begin
        if (mq.size() > 0) pop = 1;
        else begin m_out_v = 0; m_out = '0; end
      end
      inr = m_cap_v && m_cx >= 0 && m_cx < W && m_cy >= 0 && m_cy < H;
      if (m_cap_v && !inr && m_clip < 65535) m_clip++;
      nov = i_clear_overflow ? 1'b0 : m_ovf;
      a = BASE + m_cy * W + m_cx;
      nw.a = a[19:0];
      nw.d = {m_cr[7:3], m_cg[7:2], m_cb[7:3]};
      if (inr && mq.size() == DEPTH && !pop) begin
        nov = 1;
        if (m_drop < 65535) m_drop++;
        inr = 0;
      end
      if (pop) begin m_out = mq.pop_front(); m_out_v = 1; end
      if (inr) mq.push_back(nw);
      m_ovf = nov;
      m_cap_v = i_write_pixel;
      m_cx = int'($signed(i_x));
      m_cy = int'($signed(i_y));
      m_cr = i_r; m_cg = i_g; m_cb = i_b;
    end
  end

  always begin
    @(negedge i_clk);
    #1;
    if (chk_en) begin
      chk("m_req", o_mem_req, m_out_v);
      chk("m_addr", o_mem_addr, m_out_v ? m_out.a : 20'd0);
      chk("m_data", o_mem_data, m_out_v ? m_out.d : 16'd0);
      chk("m_level", o_fifo_level, mq.size());
      chk("m_ovf", o_overflow, m_ovf);
      chk("m_clip", o_clip_count, m_clip);
      chk("m_drop", o_drop_count, m_drop);
      chk("m_idle", o_idle, !m_cap_v && mq.size() == 0 && !m_out_v);
    end
  end

  task automatic drive_px(input int x, input int y, input logic [7:0] r, g, b);
    @(negedge i_clk);
    i_write_pixel = 1'b1;
    i_x = 16'(x); i_y = 16'(y);
    i_r = r; i_g = g; i_b = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge i_clk); i_write_pixel = 1'b0; end
  endtask

  typedef struct {
    int x; int y; logic [7:0] r; logic [7:0] g; logic [7:0] b;
    bit clip; logic [19:0] addr; logic [15:0] data;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int exp_clip;
    logic [19:0] got[$];
    int first_k, last_k, nreq;

    vecs[0] = '{10, 2, 8'hFF, 8'h80, 8'h08, 1'b0, 20'd650, 16'hFC01};
    vecs[1] = '{-1, 0, 8'h11, 8'h22, 8'h33, 1'b1, 20'd0, 16'h0};
    vecs[2] = '{320, 5, 8'h11, 8'h22, 8'h33, 1'b1, 20'd0, 16'h0};
    vecs[3] = '{0, 240, 8'h11, 8'h22, 8'h33, 1'b1, 20'd0, 16'h0};
    vecs[4] = '{0, 0, 8'h00, 8'h00, 8'h00, 1'b0, 20'd0, 16'h0000};
    vecs[5] = '{319, 239, 8'hFF, 8'hFF, 8'hFF, 1'b0, 20'd76799, 16'hFFFF};
    vecs[6] = '{5, 1, 8'h12, 8'h34, 8'h56, 1'b0, 20'd325, 16'h11AA};
    vecs[7] = '{0, -1, 8'h44, 8'h55, 8'h66, 1'b1, 20'd0, 16'h0};

    repeat (2) @(negedge i_clk);
    chk_en = 1'b1;
    #2;
    chk("rst_req", o_mem_req, 0);
    chk("rst_idle", o_idle, 1);
    chk("rst_level", o_fifo_level, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Vector table, ack held high
    i_mem_ack = 1'b1;
    exp_clip = 0;
    foreach (vecs[i]) begin
      drive_px(vecs[i].x, vecs[i].y, vecs[i].r, vecs[i].g, vecs[i].b);
      idle(2);
      chk("vec_early_req", o_mem_req, 0);
      idle(1);
      if (vecs[i].clip) begin
        exp_clip++;
        chk("vec_clip_noreq", o_mem_req, 0);
        chk("vec_clip_cnt", o_clip_count, exp_clip);
      end else begin
        chk("vec_req", o_mem_req, 1);
        chk("vec_addr", o_mem_addr, vecs[i].addr);
        chk("vec_data", o_mem_data, vecs[i].data);
      end
      idle(1);
      chk("vec_done_req", o_mem_req, 0);
      chk("vec_done_idle", o_idle, 1);
    end
    chk("clip_total", o_clip_count, 4);

    // Six pixels into a stalled memory: five held, one dropped, order kept
    i_mem_ack = 1'b0;
    for (int i = 0; i < 6; i++) drive_px(i, 1, 8'hA0, 8'h50, 8'h28);
    idle(4);
    chk("ovf_level", o_fifo_level, 4);
    chk("ovf_req", o_mem_req, 1);
    chk("ovf_head", o_mem_addr, 320);
    chk("ovf_drop", o_drop_count, 1);
    chk("ovf_flag", o_overflow, 1);
    i_mem_ack = 1'b1;
    got.delete();
    for (int k = 0; k < 12; k++) begin
      if (o_mem_req) got.push_back(o_mem_addr);
      @(negedge i_clk);
    end
    chk("ovf_nwrites", got.size(), 5);
    foreach (got[j]) chk("ovf_order", got[j], 320 + j);
    i_clear_overflow = 1'b1;
    @(negedge i_clk);
    i_clear_overflow = 1'b0;
    chk("clear_alone", o_overflow, 0);

    // Back-to-back writes with ack always high
    got.delete();
    first_k = -1; last_k = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge i_clk);
      if (o_mem_req) begin
        got.push_back(o_mem_addr);
        if (first_k < 0) first_k = k;
        last_k = k;
      end
      i_write_pixel = (k < 4);
      i_x = 16'(k); i_y = 16'd0;
    end
    chk("b2b_count", got.size(), 4);
    chk("b2b_span", last_k - first_k, 3);
    foreach (got[j]) chk("b2b_addr", got[j], j);

    // Clear coinciding with a drop keeps the flag set
    i_mem_ack = 1'b0;
    for (int i = 0; i < 6; i++) drive_px(10 + i, 3, 8'h01, 8'h02, 8'h03);
    @(negedge i_clk);
    i_write_pixel = 1'b0;
    i_clear_overflow = 1'b1;
    @(negedge i_clk);
    i_clear_overflow = 1'b0;
    chk("clear_drop_ovf", o_overflow, 1);
    chk("clear_drop_cnt", o_drop_count, 2);
    i_mem_ack = 1'b1;
    idle(12);
    chk("drain_idle", o_idle, 1);

    // Reset while a write is pending with two pixels buffered
    i_mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) drive_px(20 + i, 4, 8'hFF, 8'h00, 8'hFF);
    idle(3);
    chk("prerst_level", o_fifo_level, 2);
    chk("prerst_req", o_mem_req, 1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("async_req", o_mem_req, 0);
    chk("async_level", o_fifo_level, 0);
    chk("async_addr", o_mem_addr, 0);
    chk("async_idle", o_idle, 1);
    chk("async_ovf", o_overflow, 0);
    chk("async_clip", o_clip_count, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_mem_ack = 1'b1;
    nreq = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      if (o_mem_req) nreq++;
    end
    chk("postrst_noreq", nreq, 0);

    // Random traffic against the model
    begin
      int ack_pct;
      ack_pct = 50;
      for (int k = 0; k < 1500; k++) begin
        @(negedge i_clk);
        if (k % 200 == 0) ack_pct = (k / 200 % 3 == 0) ? 10 : ((k / 200 % 3 == 1) ? 90 : 50);
        i_write_pixel = ($urandom_range(0, 9) < 7);
        i_x = 16'(int'($urandom_range(0, 360)) - 20);
        i_y = 16'(int'($urandom_range(0, 260)) - 10);
        i_r = 8'($urandom); i_g = 8'($urandom); i_b = 8'($urandom);
        i_mem_ack = (int'($urandom_range(0, 99)) < ack_pct);
        i_clear_overflow = ($urandom_range(0, 19) == 0);
      end
    end
    i_clear_overflow = 1'b0;
    i_mem_ack = 1'b1;
    idle(20);
    chk("end_idle", o_idle, 1);
    chk("end_level", o_fifo_level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/framebuffer_writer.md
FRAMEBUFFER_WRITER -- requirements
Module: framebuffer_writer

Interface
REQ-001 SHALL have parameter FB_WIDTH, default 320, visible pixels per line.
REQ-002 SHALL have parameter FB_HEIGHT, default 240, visible lines.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, write-buffer entries (power of two).
REQ-004 SHALL have parameter BASE_ADDR, default 0, framebuffer base word address.
REQ-005 SHALL have port i_clk  in  1  single clock, rising edge.
REQ-006 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_write_pixel  in  1  pixel valid from the raster pipeline, no backpressure.
REQ-008 SHALL have ports i_x and i_y  in  16 each  signed pixel coordinates.
REQ-009 SHALL have ports i_r, i_g, i_b  in  8 each  pixel colour.
REQ-010 SHALL have port o_mem_req  out  1  memory write request.
REQ-011 SHALL have port o_mem_addr  out  20  word address.
REQ-012 SHALL have port o_mem_data  out  16  RGB565 data.
REQ-013 SHALL have port i_mem_ack  in  1  write accepted this cycle.
REQ-014 SHALL have port o_fifo_level  out  clog2(FIFO_DEPTH)+1  buffered entries.
REQ-015 SHALL have port o_overflow  out  1  sticky drop flag.
REQ-016 SHALL have port i_clear_overflow  in  1  clears o_overflow.
REQ-017 SHALL have ports o_clip_count and o_drop_count  out  16 each  saturating event counters.
REQ-018 SHALL have port o_idle  out  1  high when capture stage empty, FIFO empty, FSM IDLE.

Function
REQ-019 SHALL register i_write_pixel/i_x/i_y/colour into a capture stage on every rising edge.
REQ-020 SHALL discard a captured pixel with x<0, x>=FB_WIDTH, y<0 or y>=FB_HEIGHT, incrementing o_clip_count (saturate at 0xFFFF).
REQ-021 SHALL compute address = BASE_ADDR + y*FB_WIDTH + x, truncated to 20 bits.
REQ-022 SHALL pack data = {r[7:3], g[7:2], b[7:3]}.
REQ-023 SHALL push unclipped pixels into the FIFO one edge after capture.
REQ-024 SHALL accept a push when FIFO full only if a pop occurs in the same cycle; otherwise drop the pixel, set o_overflow, increment o_drop_count (saturating).
REQ-025 SHALL, when i_clear_overflow and a new drop coincide, leave o_overflow set.
REQ-026 SHALL implement FSM states IDLE and REQ.
REQ-027 IDLE: FIFO non-empty -> pop head into o_mem_addr/o_mem_data, o_mem_req=1, go REQ.
REQ-028 REQ: hold o_mem_req, o_mem_addr, o_mem_data stable until i_mem_ack sampled high.
REQ-029 REQ with ack: FIFO non-empty -> pop next, stay REQ, o_mem_req remains high (back-to-back); FIFO empty -> o_mem_req=0, go IDLE.
REQ-030 SHALL ignore i_mem_ack in IDLE.
REQ-031 Latency: pixel sampled at edge E, idle and empty -> o_mem_req high after edge E+2.
REQ-032 SHALL issue writes in arrival order, no reordering or merging.
REQ-033 o_mem_addr/o_mem_data SHALL read 0 whenever o_mem_req is low.

Reset
REQ-034 i_rst_n low SHALL immediately force o_mem_req=0, o_mem_addr=0, o_mem_data=0, o_overflow=0, counters=0, o_fifo_level=0, FSM IDLE, capture stage invalid, o_idle=1.
REQ-035 Reset mid-transaction SHALL abandon the pending write and all buffered pixels; no write issues after release without new input.

Verification
REQ-036 Single pixel x=10,y=2,r=0xFF,g=0x80,b=0x08, ack held high -> one req at E+2, addr=650, data=0xFC01, then o_idle=1.
REQ-037 Pixels (-1,0), (320,5), (0,240) -> no o_mem_req, o_clip_count=3.
REQ-038 Six consecutive valid pixels, ack low -> five held (one in output register, four in FIFO), o_drop_count=1, o_overflow=1; release ack -> five writes in input order.
REQ-039 Four pixels x=0..3,y=0, ack always high -> o_mem_req continuously high four cycles, addresses 0,1,2,3.
REQ-040 Assert i_rst_n low while in REQ with FIFO level 2 -> o_mem_req falls without clock edge, level 0; after release no writes.
REQ-041 i_clear_overflow pulsed with no drop -> o_overflow=0; pulsed coincident with a drop -> o_overflow stays 1.
